// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg
//   Shared encodings for the 3x3 keypad scanner: debouncer FSM states,
//   per-frame scan result, key-code constants, and the frame classifier.
//   Key code = 3*row + col + 1, rows and columns 0-based; 0 means no key.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } deb_state_e;

  typedef enum logic [1:0] {
    FR_NONE  = 2'd0,
    FR_KEY   = 2'd1,
    FR_MULTI = 2'd2
  } frame_res_e;

  localparam logic [3:0] KEY_NONE = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;

  typedef struct packed {
    frame_res_e res;
    logic [3:0] code;
  } frame_t;

  // hits[3*row + col] is set when that row/column crossing was seen closed
  // during the frame, so a single hit at index i is key code i+1.
  function automatic frame_t classify(input logic [8:0] hits);
    frame_t f;
    int     n;
    f.res  = FR_NONE;
    f.code = KEY_NONE;
    n      = 0;
    for (int i = 0; i < 9; i++) begin
      if (hits[i]) begin
        n++;
        f.code = 4'(i + 1);
      end
    end
    if (n == 1) begin
      f.res = FR_KEY;
    end else if (n > 1) begin
      f.res  = FR_MULTI;
      f.code = KEY_NONE;
    end
    return f;
  endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// keypad_debouncer
//   Frame-level debounce FSM. Acts only on frame_vld (one cycle per full
//   scan); needs DEBOUNCE_FRAMES identical frames to accept a press and
//   DEBOUNCE_FRAMES empty frames to accept a release.
// Ports
//   hwclk, rst     clock, synchronous active-high reset
//   frame_vld      last cycle of a scan frame
//   frame_res      frame_res_e encoding of the frame (NONE/KEY/MULTI)
//   frame_code     key code when frame_res is KEY
//   button         accepted key code, held after release
//   bstate         debounced key-held flag
//   press          one-cycle strobe as bstate rises
module keypad_debouncer
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic       frame_vld,
  input  logic [1:0] frame_res,
  input  logic [3:0] frame_code,
  output logic [3:0] button,
  output logic       bstate,
  output logic       press
);

  localparam int             CW      = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    button_d;
  logic          bstate_d, press_d;
  frame_res_e    res;

  assign res     = frame_res_e'(frame_res);
  // count never exceeds DEBOUNCE_FRAMES-1 before incrementing, so no wrap
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= KEY_NONE;
      button  <= KEY_NONE;
      bstate  <= 1'b0;
      press   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      button  <= button_d;
      bstate  <= bstate_d;
      press   <= press_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    button_d = button;
    bstate_d = bstate;
    press_d  = 1'b0;
    if (frame_vld) begin
      case (state_q)
        ST_IDLE: begin
          if (res == FR_KEY) begin
            cand_d = frame_code;
            cnt_d  = CNT_ONE;
            if (DEBOUNCE_FRAMES == 1) begin
              state_d  = ST_PRESSED;
              button_d = frame_code;
              bstate_d = 1'b1;
              press_d  = 1'b1;
            end else begin
              state_d = ST_DEB_PRESS;
            end
          end
        end
        ST_DEB_PRESS: begin
          if (res == FR_KEY) begin
            if (frame_code == cand_q) begin
              cnt_d = cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                state_d  = ST_PRESSED;
                button_d = cand_q;
                bstate_d = 1'b1;
                press_d  = 1'b1;
              end
            end else begin
              // key changed while bouncing: restart on the new one
              cand_d = frame_code;
              cnt_d  = CNT_ONE;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          // KEY or MULTI keep the original button: no roll-over
          if (res == FR_NONE) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d  = ST_IDLE;
              cnt_d    = '0;
              bstate_d = 1'b0;
            end else begin
              state_d = ST_DEB_RELEASE;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_DEB_RELEASE: begin
          if (res == FR_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d  = ST_IDLE;
              cnt_d    = '0;
              bstate_d = 1'b0;
            end
          end else begin
            // release glitch: back to held, no new strobe
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   3x3 keypad row scanner. Drives one row at a time for SCAN_TICKS cycles,
//   synchronizes the column senses, samples them on the last cycle of each
//   row, and hands a per-frame result to keypad_debouncer.
// Ports
//   hwclk, rst                      clock, synchronous active-high reset
//   keypad_r1..keypad_r3  (out)     one-hot active-high row drives
//   keypad_c1..keypad_c3  (in)      asynchronous active-high column senses
//   button[3:0]           (out)     accepted key code 1..9 (0 after reset)
//   bstate                (out)     debounced key-held flag
//   press                 (out)     one-cycle strobe on each accepted press
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_TICKS      = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       hwclk,
  input  logic       rst,
  output logic       keypad_r1,
  output logic       keypad_r2,
  output logic       keypad_r3,
  input  logic       keypad_c1,
  input  logic       keypad_c2,
  input  logic       keypad_c3,
  output logic [3:0] button,
  output logic       bstate,
  output logic       press
);

  localparam int TW = $clog2(SCAN_TICKS);

  logic [TW-1:0]   tick_q;
  logic [2:0]      row_oh_q;     // registered one-hot so row pins never glitch
  logic [1:0][2:0] sync_q;       // [0] first stage, [1] usable
  logic [1:0][2:0] row_hits_q;   // columns seen in rows 0 and 1 this frame
  logic [2:0]      cols_s;
  logic            tick_last;
  logic            frame_vld;
  frame_t          frame;

  assign cols_s    = sync_q[1];
  assign tick_last = (tick_q == TW'(SCAN_TICKS - 1));
  assign frame_vld = tick_last & row_oh_q[2];

  always_ff @(posedge hwclk) begin
    if (rst) begin
      tick_q     <= '0;
      row_oh_q   <= 3'b001;
      sync_q     <= '0;
      row_hits_q <= '0;
    end else begin
      sync_q[0] <= {keypad_c3, keypad_c2, keypad_c1};
      sync_q[1] <= sync_q[0];
      if (tick_last) begin
        tick_q   <= '0;
        row_oh_q <= {row_oh_q[1:0], row_oh_q[2]};
      end else begin
        tick_q <= tick_q + 1'b1;
      end
      // row 2 is not stored: it is consumed directly at frame end
      if (tick_last && row_oh_q[0]) row_hits_q[0] <= cols_s;
      if (tick_last && row_oh_q[1]) row_hits_q[1] <= cols_s;
    end
  end

  assign keypad_r1 = row_oh_q[0];
  assign keypad_r2 = row_oh_q[1];
  assign keypad_r3 = row_oh_q[2];

  assign frame = classify({cols_s, row_hits_q[1], row_hits_q[0]});

  keypad_debouncer #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_deb (
    .hwclk     (hwclk),
    .rst       (rst),
    .frame_vld (frame_vld),
    .frame_res (frame.res),
    .frame_code(frame.code),
    .button    (button),
    .bstate    (bstate),
    .press     (press)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Directed bench: SCAN_TICKS=4, DEBOUNCE_FRAMES=2 (12-cycle frames).
//   A key matrix model closes column j onto row r when keys[3*r+j] is set.
//   Cycle 0 is the cycle right after reset is released; frame n ends at
//   the edge that starts cycle 12*n.
module tb_keypad_scanner;

  logic       hwclk;
  logic       rst;
  logic       keypad_r1, keypad_r2, keypad_r3;
  logic       keypad_c1, keypad_c2, keypad_c3;
  logic [3:0] button;
  logic       bstate, press;
  logic [8:0] keys;

  int vectors   = 0;
  int errs      = 0;
  int press_cnt = 0;
  int p0;

  keypad_scanner #(
    .SCAN_TICKS     (4),
    .DEBOUNCE_FRAMES(2)
  ) dut (
    .hwclk    (hwclk),
    .rst      (rst),
    .keypad_r1(keypad_r1),
    .keypad_r2(keypad_r2),
    .keypad_r3(keypad_r3),
    .keypad_c1(keypad_c1),
    .keypad_c2(keypad_c2),
    .keypad_c3(keypad_c3),
    .button   (button),
    .bstate   (bstate),
    .press    (press)
  );

  assign keypad_c1 = (keys[0] & keypad_r1) | (keys[3] & keypad_r2) | (keys[6] & keypad_r3);
  assign keypad_c2 = (keys[1] & keypad_r1) | (keys[4] & keypad_r2) | (keys[7] & keypad_r3);
  assign keypad_c3 = (keys[2] & keypad_r1) | (keys[5] & keypad_r2) | (keys[8] & keypad_r3);

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  always @(posedge hwclk) press_cnt <= press_cnt + int'(press);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // leaves the bench at cycle 0
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    keys = '0;
    tick(3);
    chk("rst_r1", keypad_r1, 1);
    chk("rst_r2", keypad_r2, 0);
    chk("rst_r3", keypad_r3, 0);
    chk("rst_button", button, 0);
    chk("rst_bstate", bstate, 0);
    chk("rst_press", press, 0);

    // key 9: row 2, column 2
    keys = 9'h100;
    rst  = 1'b0;
    p0   = press_cnt;
    tick(12);
    chk("k9_f1_bstate", bstate, 0);
    chk("k9_f1_press", press, 0);
    tick(12);
    chk("k9_press", press, 1);
    chk("k9_bstate", bstate, 1);
    chk("k9_button", button, 9);
    chk("k9_row0", keypad_r1, 1);
    tick(1);
    chk("k9_press_end", press, 0);
    chk("k9_strobes", press_cnt - p0, 1);
    tick(3);
    chk("row1_r2", keypad_r2, 1);
    chk("row1_r1", keypad_r1, 0);
    keys = '0;
    tick(19);
    chk("k9_rel_hold", bstate, 1);
    tick(1);
    chk("k9_rel_bstate", bstate, 0);
    chk("k9_rel_button", button, 9);

    // key 5 bounce: one frame on, one off, then held
    keys = '0;
    do_reset();
    keys = 9'h010;
    p0   = press_cnt;
    tick(12);
    chk("k5_bounce_press", press, 0);
    keys = '0;
    tick(12);
    chk("k5_gap_bstate", bstate, 0);
    keys = 9'h010;
    tick(24);
    chk("k5_press", press, 1);
    chk("k5_button", button, 5);
    tick(1);
    chk("k5_strobes", press_cnt - p0, 1);

    // release glitch: off 1 frame, on 1 frame, off 2 frames
    tick(11);
    keys = '0;
    tick(12);
    chk("k5_rel1_bstate", bstate, 1);
    keys = 9'h010;
    tick(12);
    chk("k5_back_bstate", bstate, 1);
    chk("k5_back_press", press, 0);
    keys = '0;
    tick(23);
    chk("k5_rel2_hold", bstate, 1);
    tick(1);
    chk("k5_rel2_bstate", bstate, 0);
    chk("k5_rel2_button", button, 5);
    chk("k5_total_strobes", press_cnt - p0, 1);

    // keys 1 and 3 together from idle
    keys = '0;
    do_reset();
    keys = 9'h005;
    p0   = press_cnt;
    tick(36);
    chk("multi_bstate", bstate, 0);
    chk("multi_button", button, 0);
    chk("multi_strobes", press_cnt - p0, 0);

    // key 4 accepted, then 4+5 together, then change to 7 without release
    keys = '0;
    do_reset();
    keys = 9'h008;
    p0   = press_cnt;
    tick(24);
    chk("k4_press", press, 1);
    chk("k4_button", button, 4);
    tick(12);
    keys = 9'h018;
    tick(12);
    chk("k4_multi_button", button, 4);
    chk("k4_multi_bstate", bstate, 1);
    keys = 9'h040;
    tick(24);
    chk("k4_chg_button", button, 4);
    chk("k4_chg_bstate", bstate, 1);
    chk("k4_strobes", press_cnt - p0, 1);

    // key 2 accepted, reset while held, re-accept
    keys = '0;
    do_reset();
    keys = 9'h002;
    p0   = press_cnt;
    tick(24);
    chk("k2_press", press, 1);
    chk("k2_button", button, 2);
    tick(5);
    chk("k2_row1", keypad_r2, 1);
    rst = 1'b1;
    tick(1);
    chk("k2_rst_bstate", bstate, 0);
    chk("k2_rst_button", button, 0);
    chk("k2_rst_press", press, 0);
    chk("k2_rst_r1", keypad_r1, 1);
    chk("k2_rst_r2", keypad_r2, 0);
    rst = 1'b0;
    tick(24);
    chk("k2_re_press", press, 1);
    chk("k2_re_button", button, 2);
    tick(1);
    chk("k2_strobes", press_cnt - p0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
